im_loader: RTL and testbench

//  Program loader for instruction memory: accepts instruction words over a valid/ready stream,

---
 rtl/ir_pkg.sv | 20 ++
 rtl/im_checksum.sv | 29 ++
 rtl/im_loader.sv | 164 ++++++++++++++++
 tb/tb_im_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction controller.
// Holds the loader state encoding, the IM word stride and the default bus widths.
// No ports; imported with `import ir_pkg::*`.
package ir_pkg;

  // Default widths shared by the loader and the controller that reads IM back
  localparam int DATA_SIZE    = 32;
  localparam int IM_ADDR_SIZE = 10;

  // IM is byte addressed; each instruction occupies one 32-bit word
  localparam int IM_WORD_STRIDE = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/im_checksum.sv
// XOR accumulator over every instruction word written to IM.
// Latency: o_csum reflects an update one cycle after i_update; no backpressure.
// Ports: i_clk, i_rst_n (async active-low), i_clear, i_update, i_data -> o_csum.
module im_checksum #(
  parameter int DataSize = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clear,
  input  logic                i_update,
  input  logic [DataSize-1:0] i_data,
  output logic [DataSize-1:0] o_csum
);

  logic [DataSize-1:0] r_csum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_csum <= '0;
    end else if (i_clear) begin
      r_csum <= '0;
    end else if (i_update) begin
      r_csum <= r_csum ^ i_data;
    end
  end

  assign o_csum = r_csum;

endmodule

// File: rtl/im_loader.sv
// Program loader: streams instruction words into IM at consecutive word addresses.
// Latency: accept -> IM write 1 cycle; throughput 1 word / 2 cycles.
// Backpressure: in_ready high only in LOAD; the source holds its word otherwise.
//
// Ports:
//   clock, reset_n (async active-low)
//   start                          begin a new load (taken in IDLE/DONE only)
//   in_valid/in_data/in_last       instruction stream, in_ready back to source
//   IM_address/IM_in               IM write address (bytes) and data
//   enable_im/enable_im_write      IM chip and write enables, one cycle per word
//   total_ir                       words written; program length once done
//   load_im_done                   load finished, held until next start/reset
//   load_err                       sticky overflow: MaxIns words seen without in_last
//   load_csum                      XOR of written words, only with IM_LOADER_CHECKSUM_EN
module im_loader
  import ir_pkg::*;
#(
  parameter int DataSize   = DATA_SIZE,
  parameter int IMAddrSize = IM_ADDR_SIZE,
  parameter int IM_BASE    = 0,
  parameter int MaxIns     = 256
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DataSize-1:0]   in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [IMAddrSize-1:0] IM_address,
  output logic [DataSize-1:0]   IM_in,
  output logic                  enable_im,
  output logic                  enable_im_write,
  output logic [15:0]           total_ir,
  output logic                  load_im_done,
`ifdef IM_LOADER_CHECKSUM_EN
  output logic [DataSize-1:0]   load_csum,
`endif
  output logic                  load_err
);

  localparam logic [IMAddrSize-1:0] BASE_ADDR = IMAddrSize'(IM_BASE);
  localparam logic [IMAddrSize-1:0] STRIDE    = IMAddrSize'(IM_WORD_STRIDE);
  localparam logic [15:0]           MAX_INS_W = 16'(MaxIns);

  loader_state_t         r_state;
  loader_state_t         w_next_state;
  logic [IMAddrSize-1:0] r_im_address;
  logic [DataSize-1:0]   r_im_in;
  logic [15:0]           r_total_ir;
  logic                  r_last_q;
  logic                  r_load_err;

  logic                  w_start_load;
  logic                  w_accept;
  logic                  w_write_exit;
  logic                  w_at_max;

  // The word being written now is the MaxIns-th one
  assign w_at_max = ((r_total_ir + 16'd1) == MAX_INS_W);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_start_load    = 1'b0;
    w_accept        = 1'b0;
    w_write_exit    = 1'b0;
    in_ready        = 1'b0;
    enable_im       = 1'b0;
    enable_im_write = 1'b0;
    load_im_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_load = 1'b1;
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        enable_im       = 1'b1;
        enable_im_write = 1'b1;
        w_write_exit    = 1'b1;
        // A last word wins over the overflow limit, so a full-length
        // program terminated by in_last finishes without an error.
        if (r_last_q || w_at_max) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_LOAD;
        end
      end
      ST_DONE: begin
        load_im_done = 1'b1;
        if (start) begin
          w_start_load = 1'b1;
          w_next_state = ST_LOAD;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_im_address <= BASE_ADDR;
      r_im_in      <= '0;
      r_total_ir   <= '0;
      r_last_q     <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      if (w_start_load) begin
        r_im_address <= BASE_ADDR;
        r_total_ir   <= '0;
        r_load_err   <= 1'b0;
      end
      if (w_accept) begin
        r_im_in  <= in_data;
        r_last_q <= in_last;
      end
      if (w_write_exit) begin
        r_total_ir   <= r_total_ir + 16'd1;
        r_im_address <= r_im_address + STRIDE;
        if (!r_last_q && w_at_max) begin
          r_load_err <= 1'b1;
        end
      end
    end
  end

  assign IM_address = r_im_address;
  assign IM_in      = r_im_in;
  assign total_ir   = r_total_ir;
  assign load_err   = r_load_err;

`ifdef IM_LOADER_CHECKSUM_EN
  // Updated with the same word IM receives, so it is final once DONE is reached
  im_checksum #(
    .DataSize (DataSize)
  ) u_im_checksum (
    .i_clk    (clock),
    .i_rst_n  (reset_n),
    .i_clear  (w_start_load),
    .i_update (w_write_exit),
    .i_data   (r_im_in),
    .o_csum   (load_csum)
  );
`endif

endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;

  localparam int DW   = 32;
  localparam int AW   = 10;
  localparam int BASE = 0;
  localparam int MAXI = 4;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          start   = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          in_last  = 1'b0;
  wire           in_ready;
  wire  [AW-1:0] IM_address;
  wire  [DW-1:0] IM_in;
  wire           enable_im;
  wire           enable_im_write;
  wire  [15:0]   total_ir;
  wire           load_im_done;
  wire           load_err;
`ifdef IM_LOADER_CHECKSUM_EN
  wire  [DW-1:0] load_csum;
`endif

  always #5 clock = ~clock;

  im_loader #(
    .DataSize   (DW),
    .IMAddrSize (AW),
    .IM_BASE    (BASE),
    .MaxIns     (MAXI)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_last         (in_last),
    .in_ready        (in_ready),
    .IM_address      (IM_address),
    .IM_in           (IM_in),
    .enable_im       (enable_im),
    .enable_im_write (enable_im_write),
    .total_ir        (total_ir),
    .load_im_done    (load_im_done),
`ifdef IM_LOADER_CHECKSUM_EN
    .load_csum       (load_csum),
`endif
    .load_err        (load_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // IM model: every write strobe seen is logged in order
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            wr_bad_en = 0;

  always @(negedge clock) begin
    if (enable_im_write) begin
      wr_addr_q.push_back(IM_address);
      wr_data_q.push_back(IM_in);
      if (!enable_im) wr_bad_en++;
    end
  end

  // Program offered by the source for the current load
  logic [DW-1:0] prog[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one complete load of prog[]; last_idx < 0 means no word carries in_last.
  // Expectations come from the program alone: the load stops at the first
  // in_last or after MAXI words, whichever comes first.
  task automatic run_load(input int last_idx, input string tag);
    int            idx;
    int            acc;
    int            cyc;
    int            acc_cyc;
    int            done_cyc;
    int            exp_n;
    bit            exp_err;
    bit            taken;
    logic [DW-1:0] exp_csum;

    if (last_idx >= 0 && last_idx < MAXI) begin
      exp_n   = last_idx + 1;
      exp_err = 1'b0;
    end else begin
      exp_n   = MAXI;
      exp_err = 1'b1;
    end
    exp_csum = '0;
    for (int i = 0; i < exp_n; i++) exp_csum ^= prog[i];

    @(negedge clock);
    #1;
    start = 1'b1;
    @(negedge clock);
    #1;
    start = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    check({tag, "_start_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_start_done"}, 64'(load_im_done), 64'd0);
    check({tag, "_start_total"}, 64'(total_ir), 64'd0);
    check({tag, "_start_err"}, 64'(load_err), 64'd0);

    idx      = 0;
    acc      = 0;
    cyc      = 0;
    acc_cyc  = -100;
    done_cyc = -1;
    taken    = 1'b0;
    while (cyc < 300) begin
      if (load_im_done) begin
        done_cyc = cyc;
        break;
      end
      if (idx < prog.size()) begin
        // A raised valid is held until the word is taken
        if (taken || !in_valid) in_valid = 1'($urandom_range(0, 1));
        in_data = prog[idx];
        in_last = (idx == last_idx);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      taken = 1'b0;
      #1;
      if (in_valid && in_ready) begin
        acc++;
        acc_cyc = cyc;
        idx++;
        taken = 1'b1;
      end
      @(negedge clock);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    check({tag, "_done_seen"}, 64'(done_cyc >= 0), 64'd1);
    check({tag, "_accepted"}, 64'(acc), 64'(exp_n));
    check({tag, "_done_latency"}, 64'(done_cyc - acc_cyc), 64'd2);
    check({tag, "_total_ir"}, 64'(total_ir), 64'(exp_n));
    check({tag, "_load_err"}, 64'(load_err), 64'(exp_err));
    check({tag, "_ready_in_done"}, 64'(in_ready), 64'd0);
    check({tag, "_wr_count"}, 64'(wr_addr_q.size()), 64'(exp_n));
    check({tag, "_wr_enables"}, 64'(wr_bad_en), 64'd0);
    for (int i = 0; i < exp_n && i < wr_addr_q.size(); i++) begin
      check($sformatf("%s_wr%0d_addr", tag, i), 64'(wr_addr_q[i]), 64'(BASE + 4 * i));
      check($sformatf("%s_wr%0d_data", tag, i), 64'(wr_data_q[i]), 64'(prog[i]));
    end
`ifdef IM_LOADER_CHECKSUM_EN
    check({tag, "_csum"}, 64'(load_csum), 64'(exp_csum));
`endif

    // DONE holds with the source idle
    repeat (2) @(negedge clock);
    #1;
    check({tag, "_done_held"}, 64'(load_im_done), 64'd1);
    check({tag, "_total_held"}, 64'(total_ir), 64'(exp_n));
  endtask

  initial begin
    int len;

    // Asynchronous reset takes effect without a clock edge
    #1;
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_en", 64'(enable_im), 64'd0);
    check("rst_wen", 64'(enable_im_write), 64'd0);
    check("rst_done", 64'(load_im_done), 64'd0);
    check("rst_err", 64'(load_err), 64'd0);
    check("rst_total", 64'(total_ir), 64'd0);
    check("rst_addr", 64'(IM_address), 64'(BASE));
    check("rst_data", 64'(IM_in), 64'd0);
    repeat (2) @(negedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    check("idle_ready", 64'(in_ready), 64'd0);

    // Reset asserted in the middle of a WRITE cycle
    start = 1'b1;
    @(negedge clock);
    #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    in_last  = 1'b0;
    @(negedge clock);
    #1;
    in_valid = 1'b0;
    check("midwr_wen", 64'(enable_im_write), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midwr_rst_wen", 64'(enable_im_write), 64'd0);
    check("midwr_rst_en", 64'(enable_im), 64'd0);
    check("midwr_rst_ready", 64'(in_ready), 64'd0);
    check("midwr_rst_total", 64'(total_ir), 64'd0);
    check("midwr_rst_addr", 64'(IM_address), 64'(BASE));
    check("midwr_rst_data", 64'(IM_in), 64'd0);
    check("midwr_rst_done", 64'(load_im_done), 64'd0);
    check("midwr_rst_err", 64'(load_err), 64'd0);
`ifdef IM_LOADER_CHECKSUM_EN
    check("midwr_rst_csum", 64'(load_csum), 64'd0);
`endif
    @(negedge clock);
    #1;
    wr_addr_q.delete();
    wr_data_q.delete();
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check("midwr_idle_ready", 64'(in_ready), 64'd0);
    check("midwr_no_write", 64'(wr_addr_q.size()), 64'd0);

    // Directed three-word program
    prog = '{32'h4000_0000, 32'h5000_0001, 32'h8000_0009};
    run_load(2, "three");

    // Random programs with random valid gaps, one to MAXI words
    for (int t = 0; t < 8; t++) begin
      len = int'($urandom_range(1, MAXI));
      prog.delete();
      for (int i = 0; i < len; i++) prog.push_back($urandom);
      run_load(len - 1, $sformatf("rand%0d", t));
    end

    // MAXI-th word carries in_last: clean finish
    prog = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    run_load(3, "fullLast");

    // Overflow: five words, none marked last
    prog = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
    run_load(-1, "overflow");

    // Restart from DONE with a single word
    prog = '{32'hDEAD_BEEF};
    run_load(0, "restart");

    // XOR of the two words is 0x0FF00FF0
    prog = '{32'h0F0F_0F0F, 32'h00FF_00FF};
    run_load(1, "csum");
`ifdef IM_LOADER_CHECKSUM_EN
    check("csum_const", 64'(load_csum), 64'h0FF0_0FF0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
